inst_fetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the decode stage.
- Owns the program counter and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers returned words with their PCs in a 2-entry FIFO and presents them to decode as {inst, inst_pc} with valid/ready.
- Accepts redirects (taken branch/jump) from later stages, flushing the FIFO and discarding stale in-flight responses.

---
 rtl/inst_fetch_unit_if.sv | 42 ++++
 rtl/inst_fetch_unit.sv | 138 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle for inst_fetch_unit: instruction-memory request/response channel,
// decode-side instruction channel, redirect input and misalignment flag.
interface inst_fetch_unit_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  // Instruction memory request/response
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;

  // Decode-side instruction stream
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_valid;
  logic            inst_ready;

  // Control flow from later stages
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst, inst_pc, inst_valid,
    input  inst_ready,
    input  redirect_en, redirect_pc,
    output fetch_misaligned
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst, inst_pc, inst_valid,
    output inst_ready,
    output redirect_en, redirect_pc,
    input  fetch_misaligned
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem requests, 2-entry
// instruction FIFO, redirect flush. Optional macro: IMEM_MISALIGN_CHECK_EN.
module inst_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_pc_q;
  logic [XLEN-1:0] redirect_target;
  logic            misaligned_q;

  logic [ILEN-1:0] fifo_inst [2];
  logic [XLEN-1:0] fifo_pc   [2];
  logic            head_q;
  logic [1:0]      count_q;
  logic            wr_ptr;

  logic            req_valid;
  logic            accept;
  logic            push;
  logic            pop;
  logic            inst_valid;

`ifdef IMEM_MISALIGN_CHECK_EN
  // A misaligned target is latched as a fault and stalls fetch until an
  // aligned redirect replaces it.
  assign redirect_target = bus.redirect_pc;

  always_ff @(posedge clk) begin
    if (rst)
      misaligned_q <= 1'b0;
    else if (bus.redirect_en)
      misaligned_q <= |bus.redirect_pc[1:0];
  end
`else
  assign redirect_target = bus.redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign misaligned_q    = 1'b0;
`endif

  assign inst_valid = (count_q != 2'd0) && !rst;
  assign pop        = inst_valid && bus.inst_ready;
  assign accept     = req_valid && bus.imem_req_ready;
  assign wr_ptr     = head_q ^ count_q[0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_valid = 1'b0;
    push      = 1'b0;

    case (state_q)
      S_REQ: begin
        req_valid = (count_q != 2'd2) && !bus.redirect_en && !misaligned_q;
        if (req_valid && bus.imem_req_ready) begin
          state_d = S_WAIT;
          pc_d    = pc_q + XLEN'(4);
        end
      end
      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.imem_resp_valid)
          state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // An outstanding request that has not returned yet must be drained
    // before fetching from the new target; a same-cycle response is dropped.
    if (bus.redirect_en) begin
      push = 1'b0;
      pc_d = redirect_target;
      if (state_q != S_REQ && !bus.imem_resp_valid)
        state_d = S_DROP;
      else
        state_d = S_REQ;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      head_q       <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (accept)
        pending_pc_q <= pc_q;
      if (bus.redirect_en) begin
        head_q  <= 1'b0;
        count_q <= 2'd0;
      end else begin
        if (pop)
          head_q <= ~head_q;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; occupancy is tracked by
  // count_q and the outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= bus.imem_resp_data;
      fifo_pc[wr_ptr]   <= pending_pc_q;
    end
  end

  assign bus.imem_req_valid   = req_valid && !rst;
  assign bus.imem_req_addr    = pc_q;
  assign bus.inst_valid       = inst_valid;
  assign bus.inst             = inst_valid ? fifo_inst[head_q] : '0;
  assign bus.inst_pc          = inst_valid ? fifo_pc[head_q]   : '0;
  assign bus.fetch_misaligned = misaligned_q && !rst;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit (RESET_PC = 0x100).
// Memory word at address A is {A[15:0], ~A[15:0]}.
module tb_inst_fetch_unit;

  logic clk;
  logic rst;

  inst_fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

  inst_fetch_unit #(
    .XLEN    (32),
    .ILEN    (32),
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int resp_lat     = 1;
  int cyc          = 0;

  logic [31:0] acc_addr[$];
  logic [31:0] acc_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  logic [31:0] pop_cyc[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: in order, fixed latency resp_lat cycles after accept.
  initial begin : responder
    logic        acc;
    logic [31:0] a;
    logic [31:0] paddr;
    int          cnt;
    cnt   = 0;
    paddr = '0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      acc = bus.imem_req_valid && bus.imem_req_ready;
      a   = bus.imem_req_addr;
      @(posedge clk);
      #1;
      bus.imem_resp_valid = 1'b0;
      if (acc) begin
        cnt   = resp_lat;
        paddr = a;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data  = mem_word(paddr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        acc_addr.push_back(bus.imem_req_addr);
        acc_cyc.push_back(cyc);
      end
      if (bus.inst_valid && bus.inst_ready) begin
        pop_pc.push_back(bus.inst_pc);
        pop_inst.push_back(bus.inst);
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    rst             = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;
    repeat (5) step();
    acc_addr.delete();
    acc_cyc.delete();
    pop_pc.delete();
    pop_inst.delete();
    pop_cyc.delete();
    rst = 1'b0;
  endtask

  task automatic redirect_pulse(input logic [31:0] target);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = target;
    step();
    bus.redirect_en = 1'b0;
  endtask

  initial begin
    int hits;
    rst                = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_en    = 1'b0;
    bus.redirect_pc    = '0;

    // Outputs held quiet while reset is high
    repeat (2) step();
    @(negedge clk);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_inst_valid", bus.inst_valid, 1'b0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_misaligned", bus.fetch_misaligned, 1'b0);

    // Sequential fetch after reset, 1-cycle memory
    resp_lat = 1;
    do_reset();
    bus.inst_ready = 1'b1;
    repeat (8) step();
    check("seq_req0", q_at(acc_addr, 0), 32'h0000_0100);
    check("seq_req1", q_at(acc_addr, 1), 32'h0000_0104);
    check("seq_req2", q_at(acc_addr, 2), 32'h0000_0108);
    check("seq_req_spacing", q_at(acc_cyc, 1) - q_at(acc_cyc, 0), 32'd2);
    check("seq_first_latency", q_at(pop_cyc, 0) - q_at(acc_cyc, 0), 32'd2);
    check("seq_pc0", q_at(pop_pc, 0), 32'h0000_0100);
    check("seq_pc1", q_at(pop_pc, 1), 32'h0000_0104);
    check("seq_pc2", q_at(pop_pc, 2), 32'h0000_0108);
    check("seq_inst0", q_at(pop_inst, 0), 32'h0100_FEFF);
    check("seq_inst2", q_at(pop_inst, 2), 32'h0108_FEF7);

    // Decode stalled: two entries buffered, third request withheld
    do_reset();
    repeat (10) step();
    check("stall_req_count", acc_addr.size(), 2);
    check("stall_pop_count", pop_pc.size(), 0);
    @(negedge clk);
    check("stall_inst_valid", bus.inst_valid, 1'b1);
    check("stall_head_pc", bus.inst_pc, 32'h0000_0100);
    check("stall_no_req", bus.imem_req_valid, 1'b0);
    step();
    bus.inst_ready = 1'b1;
    repeat (6) step();
    check("stall_pop0", q_at(pop_pc, 0), 32'h0000_0100);
    check("stall_pop1", q_at(pop_pc, 1), 32'h0000_0104);
    check("stall_pop1_inst", q_at(pop_inst, 1), 32'h0104_FEFB);
    check("stall_resume_req", q_at(acc_addr, 2), 32'h0000_0108);

    // Redirect while a slow response is in flight: stale data dropped
    resp_lat = 3;
    do_reset();
    bus.inst_ready = 1'b1;
    redirect_pulse(32'h0000_0200);
    step();
    redirect_pulse(32'h0000_0400);
    repeat (12) step();
    check("drop_req0", q_at(acc_addr, 0), 32'h0000_0200);
    check("drop_req1", q_at(acc_addr, 1), 32'h0000_0400);
    check("drop_pop0_pc", q_at(pop_pc, 0), 32'h0000_0400);
    check("drop_pop0_inst", q_at(pop_inst, 0), 32'h0400_FBFF);
    hits = 0;
    foreach (pop_pc[i]) if (pop_pc[i] == 32'h0000_0200) hits++;
    check("drop_no_stale", hits, 0);

    // Redirect in the same cycle as a response that would fill the FIFO
    resp_lat = 1;
    do_reset();
    repeat (3) step();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0400;
    @(negedge clk);
    check("coll_pre_inst_valid", bus.inst_valid, 1'b1);
    check("coll_pre_resp", bus.imem_resp_valid, 1'b1);
    check("coll_redirect_no_req", bus.imem_req_valid, 1'b0);
    step();
    bus.redirect_en = 1'b0;
    @(negedge clk);
    check("coll_flushed", bus.inst_valid, 1'b0);
    check("coll_req_valid", bus.imem_req_valid, 1'b1);
    check("coll_req_addr", bus.imem_req_addr, 32'h0000_0400);
    step();
    bus.inst_ready = 1'b1;
    repeat (6) step();
    check("coll_first_pop", q_at(pop_pc, 0), 32'h0000_0400);

    // PC wraps from the top word to zero
    do_reset();
    bus.inst_ready = 1'b1;
    redirect_pulse(32'hFFFF_FFFC);
    repeat (8) step();
    check("wrap_req0", q_at(acc_addr, 0), 32'hFFFF_FFFC);
    check("wrap_req1", q_at(acc_addr, 1), 32'h0000_0000);
    check("wrap_inst0", q_at(pop_inst, 0), 32'hFFFC_0003);
    check("wrap_pc1", q_at(pop_pc, 1), 32'h0000_0000);
    check("wrap_inst1", q_at(pop_inst, 1), 32'h0000_FFFF);

    // Misaligned redirect target
    do_reset();
    bus.inst_ready = 1'b1;
`ifdef IMEM_MISALIGN_CHECK_EN
    redirect_pulse(32'h0000_0402);
    repeat (5) step();
    @(negedge clk);
    check("mis_flag_set", bus.fetch_misaligned, 1'b1);
    check("mis_no_req_valid", bus.imem_req_valid, 1'b0);
    check("mis_no_accepts", acc_addr.size(), 0);
    step();
    redirect_pulse(32'h0000_0500);
    @(negedge clk);
    check("mis_flag_clear", bus.fetch_misaligned, 1'b0);
    check("mis_req_valid", bus.imem_req_valid, 1'b1);
    check("mis_req_addr", bus.imem_req_addr, 32'h0000_0500);
`else
    redirect_pulse(32'h0000_0402);
    @(negedge clk);
    check("mis_flag_zero", bus.fetch_misaligned, 1'b0);
    check("mis_req_valid", bus.imem_req_valid, 1'b1);
    check("mis_req_addr", bus.imem_req_addr, 32'h0000_0400);
`endif
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
